// File: rtl/sbox_layer_seq_pkg.sv
// Shared PHOTON SubCells definitions: cell width, 4-bit S-box tables,
// FSM state type and the pass-count helper.
package photon_pkg;

  localparam int CELL_W = 4;

  // Nibble i of each table holds S(i) (entry 0 in bits [3:0]).
  localparam logic [63:0] SBOX_FWD = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] SBOX_INV = 64'hA970_364B_D21C_8FE5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/sbox_layer_seq_if.sv
// Valid/ready bus carrying a full PHOTON state into and out of the SubCells layer.
interface sbox_layer_seq_if #(
  parameter int NCELLS = 25
);
  localparam int SW = photon_pkg::CELL_W * NCELLS;

  logic          in_valid;
  logic          in_ready;
  logic          in_inv;
  logic [SW-1:0] in_state;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_state;

  modport master (
    output in_valid, in_inv, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_inv, in_state, out_ready,
    output in_ready, out_valid, out_state
  );

endinterface

// File: rtl/sbox_layer_seq_sbox.sv
// Single 4-bit PHOTON/PRESENT S-box with a forward/inverse select.
module sbox4_dual
  import photon_pkg::*;
(
  input  logic              inv_i,
  input  logic [CELL_W-1:0] x_i,
  output logic [CELL_W-1:0] y_o
);

  logic [5:0] base;

  assign base = {x_i, 2'b00};
  assign y_o  = inv_i ? SBOX_INV[base +: CELL_W] : SBOX_FWD[base +: CELL_W];

endmodule

// File: rtl/sbox_layer_seq.sv
// Iterative SubCells layer: substitutes LANES cells of the held state per clock
// until all NCELLS cells are done, then presents the result until taken.
module sbox_layer_seq
  import photon_pkg::*;
#(
  parameter int NCELLS = 25,
  parameter int LANES  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  sbox_layer_seq_if.slave bus
);

  localparam int SW = CELL_W * NCELLS;
  localparam int P  = ceil_div(NCELLS, LANES);
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam int NP = P * LANES;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;

  fsm_e          fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] state_q, state_d;
  logic          inv_q, inv_d;

  logic [CELL_W-1:0] cell_pad [NP];
  logic [CELL_W-1:0] lane_in  [LANES];
  logic [CELL_W-1:0] lane_out [LANES];
  logic [SW-1:0]     run_next;

  // Pad the cell array to a whole number of passes so the lane window never
  // leaves the array; padding lanes compute on zero and are never written back.
  for (genvar gi = 0; gi < NP; gi++) begin : g_pad
    if (gi < NCELLS) begin : g_cell
      assign cell_pad[gi] = state_q[gi*CELL_W +: CELL_W];
    end else begin : g_zero
      assign cell_pad[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [IW-1:0] idx;
    assign idx = IW'(32'(cnt_q) * LANES + gi);
    assign lane_in[gi] = cell_pad[idx];
    sbox4_dual u_sbox (
      .inv_i (inv_q),
      .x_i   (lane_in[gi]),
      .y_o   (lane_out[gi])
    );
  end

  // Each cell has a fixed pass and lane; it updates only in its own pass.
  for (genvar gi = 0; gi < NCELLS; gi++) begin : g_wb
    localparam int PASS = gi / LANES;
    localparam int LANE = gi % LANES;
    assign run_next[gi*CELL_W +: CELL_W] = (cnt_q == CW'(PASS)) ? lane_out[LANE]
                                                               : state_q[gi*CELL_W +: CELL_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    inv_d   = inv_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.in_state;
          inv_d   = bus.in_inv;
          cnt_d   = '0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = run_next;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(P - 1)) fsm_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  // Partial RUN contents never reach the output.
  assign bus.out_state = (fsm_q == DONE) ? state_q : '0;

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Directed bench for sbox_layer_seq: LANES=5 and LANES=4 instances checked
// against a whole-state S-box model plus hand-computed literal results.
module tb_sbox_layer_seq;

  localparam int SW = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sbox_layer_seq_if #(.NCELLS(25)) if5 ();
  sbox_layer_seq_if #(.NCELLS(25)) if4 ();

  sbox_layer_seq #(.NCELLS(25), .LANES(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));
  sbox_layer_seq #(.NCELLS(25), .LANES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  int checks = 0;
  int passed = 0;
  logic cmp_en = 1'b0;
  logic [SW-1:0] exp5 = '0;
  logic [SW-1:0] exp4 = '0;

  logic [3:0] fwd_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0] inv_t [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                             4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  localparam logic [SW-1:0] ALL0  = '0;
  localparam logic [SW-1:0] ALLC  = {25{4'hC}};
  localparam logic [SW-1:0] ALLA  = {25{4'hA}};
  localparam logic [SW-1:0] ALLF  = {25{4'hF}};
  localparam logic [SW-1:0] SEQ   = 100'h555555555_FEDC_BA98_7654_3210;
  localparam logic [SW-1:0] SEQ_F = 100'h000000000_2174_8FE3_DA09_B65C;
  localparam logic [SW-1:0] MIX   = 100'h0123456789ABCDEF0123456789;

  function automatic logic [SW-1:0] model(input logic [SW-1:0] s, input logic inv);
    logic [SW-1:0] r;
    r = '0;
    for (int c = 0; c < 25; c++) begin
      r[c*4 +: 4] = inv ? inv_t[s[c*4 +: 4]] : fwd_t[s[c*4 +: 4]];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic valid_of(input int sel);
    return (sel == 5) ? if5.out_valid : if4.out_valid;
  endfunction

  function automatic logic ready_of(input int sel);
    return (sel == 5) ? if5.in_ready : if4.in_ready;
  endfunction

  function automatic logic [SW-1:0] state_of(input int sel);
    return (sel == 5) ? if5.out_state : if4.out_state;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [SW-1:0] s, input logic inv);
    if (sel == 5) begin if5.in_valid = v; if5.in_state = s; if5.in_inv = inv; end
    else          begin if4.in_valid = v; if4.in_state = s; if4.in_inv = inv; end
  endtask

  task automatic set_oready(input int sel, input logic r);
    if (sel == 5) if5.out_ready = r;
    else          if4.out_ready = r;
  endtask

  // Every cycle: a valid output must equal the model, an idle output must be zero.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      if (if5.out_valid) chk("cmp5_state", if5.out_state, exp5);
      else               chk("cmp5_idle",  if5.out_state, '0);
      if (if4.out_valid) chk("cmp4_state", if4.out_state, exp4);
      else               chk("cmp4_idle",  if4.out_state, '0);
    end
  end

  // One transaction: accept at edge 0, result after edge p, optional backpressure
  // with a competing in_valid, then an out_ready pulse. Called at a negedge.
  task automatic run(input int sel, input logic [SW-1:0] st, input logic inv,
                     input int p, input logic [SW-1:0] lit, input int hold);
    if (sel == 5) exp5 = model(st, inv);
    else          exp4 = model(st, inv);
    set_in(sel, 1'b1, st, inv);
    @(posedge clk);
    @(negedge clk);
    set_in(sel, 1'b0, ~st, ~inv);
    chk("ready_run", ready_of(sel), 1'b0);
    for (int c = 1; c <= p; c++) begin
      @(negedge clk);
      chk((c < p) ? "valid_run" : "valid_done", valid_of(sel), (c == p));
      chk("ready_busy", ready_of(sel), 1'b0);
    end
    chk("lit_result", state_of(sel), lit);
    if (hold > 0) set_in(sel, 1'b1, MIX, ~inv);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", valid_of(sel), 1'b1);
      chk("bp_ready", ready_of(sel), 1'b0);
    end
    set_oready(sel, 1'b1);
    @(negedge clk);
    set_oready(sel, 1'b0);
    set_in(sel, 1'b0, MIX, 1'b0);
    chk("pop_valid", valid_of(sel), 1'b0);
    chk("pop_ready", ready_of(sel), 1'b1);
    @(negedge clk);
    chk("idle_ready", ready_of(sel), 1'b1);
    $display("txn lanes=%0d inv=%0d in=%h out=%h", (sel == 5) ? 5 : 4, inv, st, lit);
  endtask

  initial begin
    set_in(5, 1'b0, '0, 1'b0);
    set_in(4, 1'b0, '0, 1'b0);
    if5.out_ready = 1'b0;
    if4.out_ready = 1'b0;

    // Model pinned to hand-computed results.
    chk("pin_fwd0", model(ALL0, 1'b0), ALLC);
    chk("pin_seq",  model(SEQ, 1'b0), SEQ_F);
    chk("pin_inv",  model(SEQ_F, 1'b1), SEQ);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", if5.out_valid, 1'b0);
    chk("rst_state", if5.out_state, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", if5.in_ready, 1'b1);
    chk("rst_valid4", if4.out_valid, 1'b0);
    cmp_en = 1'b1;

    run(5, ALL0,  1'b0, 5, ALLC,  0);
    run(5, ALLC,  1'b1, 5, ALL0,  0);
    run(5, SEQ,   1'b0, 5, SEQ_F, 0);
    run(5, SEQ_F, 1'b1, 5, SEQ,   0);
    run(4, ALLA,  1'b0, 7, ALLF,  0);
    run(5, MIX,   1'b0, 5, model(MIX, 1'b0), 10);

    // Abort mid-RUN after pass k=2 has been reached.
    exp5 = model(SEQ, 1'b0);
    set_in(5, 1'b1, SEQ, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(5, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", if5.out_valid, 1'b0);
    chk("abort_state", if5.out_state, '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ready", if5.in_ready, 1'b1);
    @(negedge clk);
    run(5, SEQ, 1'b0, 5, SEQ_F, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
